// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 set-2 key decoder: prefix bytes,
// decoder states and the key event record carried through the event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // 00 and FF are receiver error/overrun markers and abort any sequence.
  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Scan-byte input and key-event output bundle of the PS/2 key decoder.
// master = producer/consumer side (receiver + game logic), slave = decoder.
interface ps2_key_decoder_if;

  logic [7:0] scan_code;
  logic       scan_ready;
  logic       key_pop;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       overflow;

  modport master (
    output scan_code, scan_ready, key_pop,
    input  key_valid, key_code, key_ext, key_break, overflow
  );

  modport slave (
    input  scan_code, scan_ready, key_pop,
    output key_valid, key_code, key_ext, key_break, overflow
  );

endinterface

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO; the head entry is presented on data_o
// whenever the FIFO is non-empty, and simultaneous push/pop is legal when full.
module key_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  key_event_t data_i,
  input  logic       pop_i,
  output key_event_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  key_event_t    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: storage has no reset; validity is tracked by count_q alone, and an
  // unreset array maps onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Head is forced to zero while empty so the outputs are clean after reset.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan byte to key event decoder: resynchronises scan_ready, folds
// E0/F0/E1 prefixes into single events, filters typematic repeats and queues.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter bit REPEAT_FILTER = 1'b1,
  parameter int PAUSE_SKIP    = 7
) (
  input logic               clk,
  input logic               reset,
  ps2_key_decoder_if.slave  bus
);

  localparam int CNT_W = $clog2(PAUSE_SKIP + 1);

  logic             sync1_q, sync2_q, prev_q;
  logic             strobe;
  logic [7:0]       byte_w;

  dec_state_t       state_q, state_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [8:0]       last_make_q, last_make_d;
  logic             last_vld_q, last_vld_d;
  logic             overflow_q, overflow_d;

  logic             emit;
  key_event_t       ev;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  key_event_t       head;

  // scan_ready comes from the PS/2 clock domain; scan_code is held stable
  // while it is high, so only the strobe needs synchronising.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.scan_ready;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign strobe = sync2_q & ~prev_q;
  assign byte_w = bus.scan_code;

  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    emit       = 1'b0;
    ev         = '{ext: 1'b0, brk: 1'b0, code: byte_w};

    if (strobe) begin
      case (state_q)
        IDLE: begin
          if (byte_w == PS2_EXT) begin
            state_d = EXT;
          end else if (byte_w == PS2_BRK) begin
            state_d = BRK;
          end else if (byte_w == PS2_PAUSE) begin
            state_d    = SKIP;
            skip_cnt_d = CNT_W'(PAUSE_SKIP);
          end else if (!is_err_byte(byte_w)) begin
            emit = 1'b1;
          end
        end
        EXT: begin
          if (byte_w == PS2_BRK) begin
            state_d = EXT_BRK;
          end else if (byte_w != PS2_EXT) begin
            state_d = IDLE;
            emit    = !is_err_byte(byte_w);
            ev.ext  = 1'b1;
          end
        end
        BRK: begin
          if (byte_w != PS2_BRK) begin
            state_d = IDLE;
            emit    = !is_err_byte(byte_w);
            ev.brk  = 1'b1;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          emit    = !is_err_byte(byte_w);
          ev.ext  = 1'b1;
          ev.brk  = 1'b1;
        end
        SKIP: begin
          skip_cnt_d = skip_cnt_q - 1'b1;
          if (skip_cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Typematic filter: a make matching the held key is swallowed; releasing
  // the held key re-arms it so the next press is reported again.
  always_comb begin
    push        = emit;
    last_make_d = last_make_q;
    last_vld_d  = last_vld_q;
    if (emit && REPEAT_FILTER) begin
      if (!ev.brk) begin
        if (last_vld_q && last_make_q == {ev.ext, ev.code}) begin
          push = 1'b0;
        end else begin
          last_make_d = {ev.ext, ev.code};
          last_vld_d  = 1'b1;
        end
      end else if (last_vld_q && last_make_q == {ev.ext, ev.code}) begin
        last_vld_d = 1'b0;
      end
    end
  end

  assign pop        = bus.key_pop & ~fifo_empty;
  assign overflow_d = push & fifo_full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      skip_cnt_q  <= '0;
      last_make_q <= '0;
      last_vld_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      last_make_q <= last_make_d;
      last_vld_q  <= last_vld_d;
      overflow_q  <= overflow_d;
    end
  end

  key_event_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .data_i  (ev),
    .pop_i   (bus.key_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.key_valid = ~fifo_empty;
  assign bus.key_code  = head.code;
  assign bus.key_ext   = head.ext;
  assign bus.key_break = head.brk;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scan-byte sequences push the
// hand-derived events into a queue; a monitor compares each popped head.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(
    .FIFO_DEPTH    (4),
    .REPEAT_FILTER (1'b1),
    .PAUSE_SKIP    (7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks    = 0;
  int         n_fail      = 0;
  int         ovf_cnt     = 0;
  int         ovf_mark    = 0;
  bit         auto_pop    = 1'b1;
  bit         man_pop_req = 1'b0;
  key_event_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk);
    exp_q.push_back('{ext: ext, brk: brk, code: code});
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold = 3);
    @(negedge clk);
    bus.scan_code  = b;
    bus.scan_ready = 1'b1;
    repeat (hold) @(negedge clk);
    bus.scan_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !bus.key_valid) break;
      @(negedge clk);
    end
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_valid"}, 32'(bus.key_valid), 32'd0);
  endtask

  // Monitor: decides on the falling edge whether to pop, and compares the
  // head that the next rising edge will consume.
  initial begin
    bus.key_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bus.key_valid && (auto_pop || man_pop_req)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got code=%0h ext=%0b brk=%0b, expected none",
                   bus.key_code, bus.key_ext, bus.key_break);
        end else begin
          key_event_t e;
          e = exp_q.pop_front();
          check("event", 32'({bus.key_ext, bus.key_break, bus.key_code}),
                32'({e.ext, e.brk, e.code}));
        end
        bus.key_pop = 1'b1;
        man_pop_req = 1'b0;
      end else begin
        bus.key_pop = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.overflow) ovf_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b0;
    bus.scan_code  = 8'h00;
    bus.scan_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bus.key_valid, bus.overflow, bus.key_ext, bus.key_break, bus.key_code}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single make: key_valid appears exactly one clock after the strobe cycle.
    expect_ev(8'h1C, 1'b0, 1'b0);
    @(negedge clk);
    bus.scan_code  = 8'h1C;
    bus.scan_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 check("latency_strobe_cycle", 32'(bus.key_valid), 32'd0);
    @(posedge clk);
    #1 check("latency_plus_one", 32'(bus.key_valid), 32'd1);
    repeat (2) @(negedge clk);
    bus.scan_ready = 1'b0;
    repeat (4) @(negedge clk);
    wait_drain("single_make");

    // Extended break collapses to one event.
    expect_ev(8'h75, 1'b1, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    wait_drain("ext_break");

    // A different make re-targets the held key away from 1C first.
    expect_ev(8'h5A, 1'b0, 1'b0);
    send_byte(8'h5A);
    wait_drain("spacer");

    expect_ev(8'h1C, 1'b0, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b1);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h1C);
    wait_drain("repeat_filter");

    // Pause sequence is swallowed; the following make comes through.
    expect_ev(8'h29, 1'b0, 1'b0);
    send_byte(8'hE1);
    send_byte(8'h14);
    send_byte(8'h77);
    send_byte(8'hE1);
    send_byte(8'hF0);
    send_byte(8'h14);
    send_byte(8'hF0);
    send_byte(8'h77);
    send_byte(8'h29);
    wait_drain("pause_skip");

    // Fill the FIFO without popping; the fifth make overflows.
    auto_pop = 1'b0;
    ovf_mark = ovf_cnt;
    expect_ev(8'h15, 1'b0, 1'b0);
    expect_ev(8'h1D, 1'b0, 1'b0);
    expect_ev(8'h24, 1'b0, 1'b0);
    expect_ev(8'h2D, 1'b0, 1'b0);
    send_byte(8'h15);
    send_byte(8'h1D);
    send_byte(8'h24);
    send_byte(8'h2D);
    check("ovf_none_until_full", 32'(ovf_cnt - ovf_mark), 32'd0);
    send_byte(8'h2C);
    check("ovf_on_fifth", 32'(ovf_cnt - ovf_mark), 32'd1);
    check("valid_when_full", 32'(bus.key_valid), 32'd1);

    // Pop and push in the same cycle while full: nothing dropped, still full.
    expect_ev(8'h1B, 1'b0, 1'b0);
    @(negedge clk);
    bus.scan_code  = 8'h1B;
    bus.scan_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 man_pop_req = 1'b1;
    @(posedge clk);
    #1 check("pop_push_full_no_ovf", 32'(ovf_cnt - ovf_mark), 32'd1);
    repeat (2) @(negedge clk);
    bus.scan_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("pop_push_no_late_ovf", 32'(ovf_cnt - ovf_mark), 32'd1);
    send_byte(8'h2E);
    check("still_full_after_pop_push", 32'(ovf_cnt - ovf_mark), 32'd2);
    auto_pop = 1'b1;
    wait_drain("fifo_drain");

    // Reset in the middle of an extended sequence discards it.
    send_byte(8'hE0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midseq_reset_outputs", 32'({bus.key_valid, bus.overflow, bus.key_ext, bus.key_break, bus.key_code}), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    expect_ev(8'h6B, 1'b0, 1'b0);
    send_byte(8'h6B);
    wait_drain("midseq_reset");

    // A level held high for many cycles is consumed only once.
    expect_ev(8'h3A, 1'b0, 1'b0);
    send_byte(8'h3A, 20);
    repeat (10) @(negedge clk);
    wait_drain("held_level");

    check("ovf_total", 32'(ovf_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
